eu_sequencer: RTL and testbench

//  Sequences one instruction at a time through register-file read, execution-unit evaluation and write-back.

---
 rtl/eu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_eu_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_sequencer.sv
// Single-issue RD/EX/WB sequencer between decode, the execution unit and the RF.
// EU_SEQ_PERF_CNT_EN adds retired_cnt_o/illegal_cnt_o performance counters.
package simple_processor_pkg;
  parameter int DATA_WIDTH = 32;
  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_ADDI = 4'd1,
    FN_SUB  = 4'd2,
    FN_AND  = 4'd3,
    FN_OR   = 4'd4,
    FN_XOR  = 4'd5,
    FN_NOT  = 4'd6,
    FN_SLL  = 4'd7,
    FN_SLLI = 4'd8,
    FN_SLR  = 4'd9,
    FN_SLRI = 4'd10
  } func_t;
endpackage

module eu_sequencer
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  func_t                 func_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [5:0]            imm_i,
  output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,
  output logic [DATA_WIDTH-1:0] eu_rs1_data_o,
  output logic [DATA_WIDTH-1:0] eu_rs2_data_o,
  output func_t                 eu_func_o,
  output logic [5:0]            eu_imm_o,
  input  logic [DATA_WIDTH-1:0] res_math_i,
  input  logic [DATA_WIDTH-1:0] res_gate_i,
  input  logic [DATA_WIDTH-1:0] res_shift_i,
  output logic                  wb_en_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
`ifdef EU_SEQ_PERF_CNT_EN
  output logic [31:0]           retired_cnt_o,
  output logic [31:0]           illegal_cnt_o,
`endif
  output logic                  illegal_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  func_t                 func_q;
  logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [5:0]            imm_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, res_q, res_d;
  logic                  ill_q, ill_d;
  logic                  accept;

  assign accept = (state_q == S_IDLE) && instr_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      func_q  <= FN_ADD;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        func_q <= func_i;
        rd_q   <= rd_addr_i;
        rs1_q  <= rs1_addr_i;
        rs2_q  <= rs2_addr_i;
        imm_q  <= imm_i;
      end
      if (state_q == S_RD) begin
        op1_q <= rf_rs1_data_i;
        op2_q <= rf_rs2_data_i;
      end
      if (state_q == S_EX) begin
        res_q <= res_d;
        ill_q <= ill_d;
      end
    end
  end

  // Result class decode; anything outside the three EU classes retires illegal.
  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    case (func_q)
      FN_ADD, FN_ADDI, FN_SUB:          res_d = res_math_i;
      FN_AND, FN_OR, FN_XOR, FN_NOT:    res_d = res_gate_i;
      FN_SLL, FN_SLLI, FN_SLR, FN_SLRI: res_d = res_shift_i;
      default:                          ill_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    busy_o        = 1'b1;
    rf_rs1_addr_o = rs1_q;
    rf_rs2_addr_o = rs2_q;
    eu_rs1_data_o = '0;
    eu_rs2_data_o = '0;
    eu_func_o     = FN_ADD;
    eu_imm_o      = '0;
    wb_en_o       = 1'b0;
    wb_addr_o     = '0;
    wb_data_o     = '0;
    illegal_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        busy_o        = 1'b0;
        rf_rs1_addr_o = rs1_addr_i;
        rf_rs2_addr_o = rs2_addr_i;
        if (instr_valid_i) state_d = S_RD;
      end
      S_RD: state_d = S_EX;
      S_EX: begin
        eu_rs1_data_o = op1_q;
        eu_rs2_data_o = op2_q;
        eu_func_o     = func_q;
        eu_imm_o      = imm_q;
        state_d       = S_WB;
      end
      S_WB: begin
        wb_en_o   = !ill_q && (rd_q != '0);
        wb_addr_o = rd_q;
        wb_data_o = ill_q ? '0 : res_q;
        illegal_o = ill_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EU_SEQ_PERF_CNT_EN
  logic [31:0] retired_q, illcnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retired_q <= '0;
      illcnt_q  <= '0;
    end else if (state_q == S_WB) begin
      retired_q <= retired_q + 32'd1;
      if (ill_q) illcnt_q <= illcnt_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_q;
  assign illegal_cnt_o = illcnt_q;
`endif

endmodule

// File: tb/tb_eu_sequencer.sv
// Directed self-checking bench for eu_sequencer.
// Models a 1-cycle-latency register file and a combinational EU.
module tb_eu_sequencer;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i;
  logic        instr_ready_o;
  func_t       func_i;
  logic [4:0]  rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic [5:0]  imm_i;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
  logic [31:0] eu_rs1_data_o, eu_rs2_data_o;
  func_t       eu_func_o;
  logic [5:0]  eu_imm_o;
  logic [31:0] res_math_i, res_gate_i, res_shift_i;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        illegal_o, busy_o;
`ifdef EU_SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_o, illegal_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  eu_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .func_i(func_i), .rd_addr_i(rd_addr_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .imm_i(imm_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .eu_rs1_data_o(eu_rs1_data_o), .eu_rs2_data_o(eu_rs2_data_o),
    .eu_func_o(eu_func_o), .eu_imm_o(eu_imm_o),
    .res_math_i(res_math_i), .res_gate_i(res_gate_i),
    .res_shift_i(res_shift_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
`ifdef EU_SEQ_PERF_CNT_EN
    .retired_cnt_o(retired_cnt_o), .illegal_cnt_o(illegal_cnt_o),
`endif
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always @(posedge clk) begin
    rf_rs1_data_i <= rf[rf_rs1_addr_o];
    rf_rs2_data_i <= rf[rf_rs2_addr_o];
  end

  // Each class bus only carries its own ops so a wrong-class select is visible.
  always_comb begin
    logic [31:0] a, b, ix;
    a = eu_rs1_data_o;
    b = eu_rs2_data_o;
    ix = {{26{eu_imm_o[5]}}, eu_imm_o};
    res_math_i = 32'h0;
    res_gate_i = 32'h0;
    res_shift_i = 32'h0;
    case (eu_func_o)
      FN_ADD:  res_math_i = a + b;
      FN_ADDI: res_math_i = a + ix;
      FN_SUB:  res_math_i = a - b;
      FN_AND:  res_gate_i = a & b;
      FN_OR:   res_gate_i = a | b;
      FN_XOR:  res_gate_i = a ^ b;
      FN_NOT:  res_gate_i = ~a;
      FN_SLL:  res_shift_i = a << b[4:0];
      FN_SLLI: res_shift_i = a << ix[4:0];
      FN_SLR:  res_shift_i = a >> b[4:0];
      FN_SLRI: res_shift_i = a >> ix[4:0];
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns #1 after its accept edge (RD cycle).
  task automatic send(input func_t f, input logic [4:0] rd,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [5:0] im);
    int n;
    n = 0;
    func_i = f;
    rd_addr_i = rd;
    rs1_addr_i = s1;
    rs2_addr_i = s2;
    imm_i = im;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout got %b want 1", instr_ready_o);
    end
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    instr_valid_i = 1'b0;
    func_i = FN_ADD;
    rd_addr_i = '0;
    rs1_addr_i = '0;
    rs2_addr_i = '0;
    imm_i = '0;
    tick();
    tick();
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", instr_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL rst_wb_en got %b want 0", wb_en_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", illegal_o); end
    checks++; if ({wb_addr_o, wb_data_o} !== 37'h0) begin errors++; $display("FAIL rst_wb_bus got %h want 0", {wb_addr_o, wb_data_o}); end
    checks++; if ({eu_rs1_data_o, eu_rs2_data_o, eu_imm_o} !== 70'h0) begin errors++; $display("FAIL rst_eu_bus got %h want 0", {eu_rs1_data_o, eu_rs2_data_o}); end
    checks++; if ({rf_rs1_addr_o, rf_rs2_addr_o} !== 10'h0) begin errors++; $display("FAIL rst_rf_addr got %h want 0", {rf_rs1_addr_o, rf_rs2_addr_o}); end
`ifdef EU_SEQ_PERF_CNT_EN
    checks++; if ({retired_cnt_o, illegal_cnt_o} !== 64'h0) begin errors++; $display("FAIL rst_cnt got %h want 0", {retired_cnt_o, illegal_cnt_o}); end
`endif
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_add;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    send(FN_ADD, 5'd3, 5'd1, 5'd2, 6'd0);
    checks++; if (busy_o !== 1'b1 || instr_ready_o !== 1'b0) begin errors++; $display("FAIL add_rd_busy got %b%b want 10", busy_o, instr_ready_o); end
    checks++; if ({rf_rs1_addr_o, rf_rs2_addr_o} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_rf_addr got %h want %h", {rf_rs1_addr_o, rf_rs2_addr_o}, {5'd1, 5'd2}); end
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL add_rd_wb got %b want 0", wb_en_o); end
    tick();
    checks++; if (eu_rs1_data_o !== 32'd5 || eu_rs2_data_o !== 32'd7) begin errors++; $display("FAIL add_ex_ops got %0d,%0d want 5,7", eu_rs1_data_o, eu_rs2_data_o); end
    checks++; if (eu_func_o !== FN_ADD) begin errors++; $display("FAIL add_ex_func got %0d want %0d", eu_func_o, FN_ADD); end
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL add_ex_wb got %b want 0", wb_en_o); end
    tick();
    checks++; if (wb_en_o !== 1'b1) begin errors++; $display("FAIL add_wb_en got %b want 1", wb_en_o); end
    checks++; if (wb_addr_o !== 5'd3) begin errors++; $display("FAIL add_wb_addr got %0d want 3", wb_addr_o); end
    checks++; if (wb_data_o !== 32'd12) begin errors++; $display("FAIL add_wb_data got %0d want 12", wb_data_o); end
    checks++; if (eu_rs1_data_o !== 32'd0) begin errors++; $display("FAIL add_wb_eu_zero got %h want 0", eu_rs1_data_o); end
    tick();
    checks++; if (wb_en_o !== 1'b0 || wb_data_o !== 32'd0) begin errors++; $display("FAIL add_post_wb got %b/%h want 0/0", wb_en_o, wb_data_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL add_ready_back got %b want 1", instr_ready_o); end
  endtask

  task automatic test_addi_sub;
    rf[5] = 32'd10;
    send(FN_ADDI, 5'd4, 5'd5, 5'd0, 6'h3F);
    tick();
    checks++; if (eu_imm_o !== 6'h3F) begin errors++; $display("FAIL addi_imm got %h want 3f", eu_imm_o); end
    tick();
    checks++; if (wb_en_o !== 1'b1 || wb_addr_o !== 5'd4 || wb_data_o !== 32'd9) begin errors++; $display("FAIL addi_wb got %b/%0d/%0d want 1/4/9", wb_en_o, wb_addr_o, wb_data_o); end
    tick();
    rf[6] = 32'd3;
    rf[7] = 32'd5;
    send(FN_SUB, 5'd9, 5'd6, 5'd7, 6'd0);
    tick();
    tick();
    checks++; if (wb_en_o !== 1'b1 || wb_addr_o !== 5'd9 || wb_data_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wb got %b/%0d/%h want 1/9/fffffffe", wb_en_o, wb_addr_o, wb_data_o); end
    tick();
    rf[11] = 32'h0000_00F0;
    send(FN_SLRI, 5'd12, 5'd11, 5'd0, 6'd4);
    tick();
    tick();
    checks++; if (wb_en_o !== 1'b1 || wb_data_o !== 32'h0000_000F) begin errors++; $display("FAIL slri_wb got %b/%h want 1/0000000f", wb_en_o, wb_data_o); end
    tick();
  endtask

  task automatic test_rd_zero;
    int seen;
    seen = 0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    send(FN_XOR, 5'd0, 5'd1, 5'd2, 6'd0);
    for (int i = 0; i < 3; i++) begin
      if (wb_en_o !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rd0_wb_en got %0d pulses want 0", seen); end
    checks++; if (instr_ready_o !== 1'b1 || illegal_o !== 1'b0) begin errors++; $display("FAIL rd0_ready got %b/%b want 1/0", instr_ready_o, illegal_o); end
  endtask

  task automatic test_illegal;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    send(func_t'(4'hF), 5'd6, 5'd1, 5'd2, 6'd0);
    tick();
    tick();
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b want 1", illegal_o); end
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL ill_wb_en got %b want 0", wb_en_o); end
    tick();
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL ill_pulse_end got %b want 0", illegal_o); end
`ifdef EU_SEQ_PERF_CNT_EN
    checks++; if (retired_cnt_o !== 32'd1) begin errors++; $display("FAIL ill_retired_cnt got %0d want 1", retired_cnt_o); end
    checks++; if (illegal_cnt_o !== 32'd1) begin errors++; $display("FAIL ill_illegal_cnt got %0d want 1", illegal_cnt_o); end
`endif
  endtask

  task automatic test_reset_mid;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    send(FN_SLL, 5'd7, 5'd1, 5'd2, 6'd0);
    tick();
    checks++; if (eu_func_o !== FN_SLL) begin errors++; $display("FAIL rmid_in_ex got %0d want %0d", eu_func_o, FN_SLL); end
    rst_ni = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0 || instr_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b%b want 01", busy_o, instr_ready_o); end
    checks++; if (wb_en_o !== 1'b0 || illegal_o !== 1'b0 || wb_data_o !== 32'd0) begin errors++; $display("FAIL rmid_outs got %b/%b/%h want 0/0/0", wb_en_o, illegal_o, wb_data_o); end
    checks++; if (eu_rs1_data_o !== 32'd0 || eu_rs2_data_o !== 32'd0) begin errors++; $display("FAIL rmid_eu got %h/%h want 0/0", eu_rs1_data_o, eu_rs2_data_o); end
    rst_ni = 1'b1;
    tick();
    checks++; if (wb_en_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_after got %b/%b want 0/0", wb_en_o, busy_o); end
  endtask

  task automatic test_back_to_back;
    int acc, nrdy, wbn, bad;
    int at [3];
    acc = 0;
    nrdy = 0;
    wbn = 0;
    bad = 0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    func_i = FN_AND;
    rd_addr_i = 5'd8;
    rs1_addr_i = 5'd1;
    rs2_addr_i = 5'd2;
    imm_i = 6'd0;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready_o === 1'b1) begin
        if (acc < 3) at[acc] = i;
        acc++;
      end else nrdy++;
      if (wb_en_o === 1'b1) begin
        wbn++;
        if (wb_data_o !== 32'd5 || wb_addr_o !== 5'd8) bad++;
      end
      tick();
    end
    instr_valid_i = 1'b0;
    checks++; if (acc != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", acc); end
    checks++; if (acc == 3 && (at[1] - at[0] != 4 || at[2] - at[1] != 4)) begin errors++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", at[1] - at[0], at[2] - at[1]); end
    checks++; if (nrdy != 9) begin errors++; $display("FAIL b2b_not_ready got %0d want 9", nrdy); end
    checks++; if (wbn != 3 || bad != 0) begin errors++; $display("FAIL b2b_writes got %0d bad %0d want 3 bad 0", wbn, bad); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    test_reset();
    test_add();
    test_addi_sub();
    test_rd_zero();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
